// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and dmem size codes for the data-memory arbiter
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // A write size code wins over a read size code, so only pure reads return data.
    function automatic logic is_read(input logic [1:0] we, input logic [1:0] r);
        return (r != SZ_NONE) && (we == SZ_NONE);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin selector; pointer picks the winner only on contention
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       pointer,
    output logic [1:0] grant
);

    assign grant[0] = valid[0] & (~valid[1] | ~pointer);
    assign grant[1] = valid[1] & (~valid[0] |  pointer);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - arbitrates two requesters onto one single-port data memory
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [1:0]        req0_we,
    input  logic [1:0]        req0_r,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [1:0]        req1_we,
    input  logic [1:0]        req1_r,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] dmem_daddr,
    output logic [1:0]        dmem_we,
    output logic [DATA_W-1:0] dmem_indata,
    output logic [1:0]        dmem_r,
    input  logic [DATA_W-1:0] dmem_outdata
);

    state_t            state, state_nxt;
    logic              ptr;
    logic [1:0]        grant;
    logic              accept;
    logic [1:0]        rdy;
    logic [1:0]        rv;
    logic [ADDR_W-1:0] cap_addr;
    logic [1:0]        cap_we;
    logic [1:0]        cap_r;
    logic [DATA_W-1:0] cap_wdata;
    logic              cap_idx;

    rr_arb2 u_rr_arb2 (
        .valid   ({req1_valid, req0_valid}),
        .pointer (ptr),
        .grant   (grant)
    );

    assign accept = (state == ST_IDLE) && (grant != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= 1'b0;
            cap_addr  <= '0;
            cap_we    <= SZ_NONE;
            cap_r     <= SZ_NONE;
            cap_wdata <= '0;
            cap_idx   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cap_addr  <= grant[1] ? req1_addr  : req0_addr;
                cap_we    <= grant[1] ? req1_we    : req0_we;
                cap_r     <= grant[1] ? req1_r     : req0_r;
                cap_wdata <= grant[1] ? req1_wdata : req0_wdata;
                cap_idx   <= grant[1];
                ptr       <= ~grant[1];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rdy       = 2'b00;
        rv        = 2'b00;
        dmem_we   = SZ_NONE;
        dmem_r    = SZ_NONE;
        case (state)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    rdy       = grant;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                dmem_we   = cap_we;
                dmem_r    = (cap_we != SZ_NONE) ? SZ_NONE : cap_r;
                state_nxt = is_read(cap_we, cap_r) ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                rv[cap_idx] = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // The grant path is combinational, so it must be masked while reset holds the FSM.
        if (reset) begin
            rdy = 2'b00;
        end
    end

    assign req0_ready  = rdy[0];
    assign req1_ready  = rdy[1];
    assign req0_rvalid = rv[0];
    assign req1_rvalid = rv[1];
    assign req0_rdata  = rv[0] ? dmem_outdata : '0;
    assign req1_rdata  = rv[1] ? dmem_outdata : '0;
    assign dmem_daddr  = cap_addr;
    assign dmem_indata = cap_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int NCYC = 1500;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
    logic [1:0]  req0_we, req1_we, req0_r, req1_r;
    logic        req0_ready, req1_ready, req0_rvalid, req1_rvalid;
    logic [31:0] req0_rdata, req1_rdata;
    logic [31:0] dmem_daddr, dmem_indata;
    logic [31:0] dmem_outdata = 32'h0;
    logic [1:0]  dmem_we, dmem_r;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_we      (req0_we),
        .req0_r       (req0_r),
        .req0_wdata   (req0_wdata),
        .req0_ready   (req0_ready),
        .req0_rvalid  (req0_rvalid),
        .req0_rdata   (req0_rdata),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_we      (req1_we),
        .req1_r       (req1_r),
        .req1_wdata   (req1_wdata),
        .req1_ready   (req1_ready),
        .req1_rvalid  (req1_rvalid),
        .req1_rdata   (req1_rdata),
        .dmem_daddr   (dmem_daddr),
        .dmem_we      (dmem_we),
        .dmem_indata  (dmem_indata),
        .dmem_r       (dmem_r),
        .dmem_outdata (dmem_outdata)
    );

    // Memory emulator: samples on the edge ending ISSUE, presents read data during WAIT.
    logic [31:0] emu_mem [logic [31:0]];
    always @(posedge clk) begin
        if (dmem_we != 2'b00) emu_mem[dmem_daddr] = dmem_indata;
        if (dmem_r != 2'b00)
            dmem_outdata <= emu_mem.exists(dmem_daddr) ? emu_mem[dmem_daddr] : 32'h0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] a0, input logic [1:0] we0,
                         input logic [1:0] r0, input logic [31:0] wd0,
                         input logic v1, input logic [31:0] a1, input logic [1:0] we1,
                         input logic [1:0] r1, input logic [31:0] wd1);
        req0_valid = v0; req0_addr = a0; req0_we = we0; req0_r = r0; req0_wdata = wd0;
        req1_valid = v1; req1_addr = a1; req1_we = we1; req1_r = r1; req1_wdata = wd1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic        v0;
        logic [31:0] a0;
        logic [1:0]  we0, r0;
        logic [31:0] wd0;
        logic        v1;
        logic [31:0] a1;
        logic [1:0]  we1, r1;
        logic [31:0] wd1;
        logic [1:0]  e_rdy, e_we, e_r, e_rv;
        logic [31:0] e_addr, e_data;
    } vec_t;

    function automatic vec_t mk(input logic v0, input logic [31:0] a0, input logic [1:0] we0,
                                input logic [1:0] r0, input logic [31:0] wd0,
                                input logic v1, input logic [31:0] a1, input logic [1:0] we1,
                                input logic [1:0] r1, input logic [31:0] wd1,
                                input logic [1:0] e_rdy, input logic [1:0] e_we,
                                input logic [1:0] e_r, input logic [31:0] e_addr,
                                input logic [1:0] e_rv, input logic [31:0] e_data);
        vec_t t;
        t.v0 = v0; t.a0 = a0; t.we0 = we0; t.r0 = r0; t.wd0 = wd0;
        t.v1 = v1; t.a1 = a1; t.we1 = we1; t.r1 = r1; t.wd1 = wd1;
        t.e_rdy = e_rdy; t.e_we = e_we; t.e_r = e_r; t.e_addr = e_addr;
        t.e_rv = e_rv; t.e_data = e_data;
        return t;
    endfunction

    vec_t tbl [16];

    // Random-phase requester state and cycle-indexed expectations
    bit          pend [2];
    logic [31:0] pa [2], pw [2];
    logic [1:0]  pwe [2], pr [2];
    logic [1:0]  x_we [NCYC+4], x_r [NCYC+4], x_rv [NCYC+4];
    logic [31:0] x_addr [NCYC+4], x_wd [NCYC+4], x_rd [NCYC+4];
    logic [31:0] ref_mem [logic [31:0]];

    initial begin
        int    gidx [$];
        int    gcyc [$];
        int    free_c;
        bit    rptr;
        int    w;
        logic [1:0]  exp_rdy, op_we, op_r;
        logic [63:0] exp_rd;

        // Reset state, with both valids high to prove ready is masked
        drive(1, 32'h44, 2'b11, 2'b00, 32'h55, 1, 32'h88, 2'b00, 2'b11, 32'h66);
        #3;
        check("rst_ready", {req1_ready, req0_ready}, 2'b00);
        check("rst_rvalid", {req1_rvalid, req0_rvalid}, 2'b00);
        check("rst_we_r", {dmem_we, dmem_r}, 4'h0);
        check("rst_addr_data", {dmem_daddr, dmem_indata}, 64'h0);
        check("rst_rdata", {req1_rdata, req0_rdata}, 64'h0);

        // Directed table: write, read-back, conflict, payload change, no-op
        tbl[0]  = mk(1, 32'h10, 2'b11, 2'b00, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 2'b00, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 32'h10, 2'b00, 32'hDEADBEEF);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 1, 32'h10, 2'b00, 2'b11, 0, 2'b10, 2'b00, 2'b00, 0, 2'b00, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 32'h10, 2'b00, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 32'hDEADBEEF);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0);
        tbl[7]  = mk(1, 32'h30, 2'b10, 2'b11, 32'h12345678, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 2'b00, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 32'h30, 2'b00, 32'h12345678);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 32'h20, 2'b01, 2'b00, 32'hAA, 2'b10, 2'b00, 2'b00, 0, 2'b00, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 1, 32'h40, 2'b01, 2'b00, 32'hBB, 2'b00, 2'b01, 2'b00, 32'h20, 2'b00, 32'hAA);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0);
        tbl[13] = mk(1, 32'h50, 2'b00, 2'b00, 32'h77, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 2'b00, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1 drive(tbl[i].v0, tbl[i].a0, tbl[i].we0, tbl[i].r0, tbl[i].wd0,
                     tbl[i].v1, tbl[i].a1, tbl[i].we1, tbl[i].r1, tbl[i].wd1);
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), {req1_ready, req0_ready}, tbl[i].e_rdy);
            check($sformatf("tbl%0d_we_r", i), {dmem_we, dmem_r}, {tbl[i].e_we, tbl[i].e_r});
            check($sformatf("tbl%0d_rvalid", i), {req1_rvalid, req0_rvalid}, tbl[i].e_rv);
            check($sformatf("tbl%0d_rdata", i), {req1_rdata, req0_rdata},
                  {tbl[i].e_rv[1] ? tbl[i].e_data : 32'h0, tbl[i].e_rv[0] ? tbl[i].e_data : 32'h0});
            if ((tbl[i].e_we | tbl[i].e_r) != 2'b00)
                check($sformatf("tbl%0d_daddr", i), dmem_daddr, tbl[i].e_addr);
            if (tbl[i].e_we != 2'b00)
                check($sformatf("tbl%0d_indata", i), dmem_indata, tbl[i].e_data);
        end

        // Contention: continuous reads from both sides after reset
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1 drive(1, 32'h10, 2'b00, 2'b11, 0, 1, 32'h30, 2'b00, 2'b11, 0);
            @(negedge clk);
            if (req0_ready && req1_ready) check("cont_onehot", 2'b11, 2'b01);
            if (req0_ready || req1_ready) begin
                gidx.push_back(int'(req1_ready));
                gcyc.push_back(c);
            end
        end
        check("cont_count", gidx.size(), 4);
        for (int i = 0; i < gidx.size() && i < 4; i++) begin
            check($sformatf("cont_idx%0d", i), gidx[i], i % 2);
            check($sformatf("cont_cyc%0d", i), gcyc[i], 3 * i);
        end

        // Reset during WAIT aborts the read and clears the pointer
        do_reset();
        @(posedge clk);
        #1 drive(1, 32'h10, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rw_grant", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rw_issue_r", dmem_r, 2'b11);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rw_rvalid", {req1_rvalid, req0_rvalid}, 2'b00);
        check("rw_we_r", {dmem_we, dmem_r}, 4'h0);
        check("rw_rdata", req0_rdata, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1, 32'h10, 2'b00, 2'b11, 0, 1, 32'h30, 2'b00, 2'b11, 0);
        @(negedge clk);
        check("rw_ptr_after_reset", {req1_ready, req0_ready}, 2'b01);
        check("rw_no_late_rvalid", {req1_rvalid, req0_rvalid}, 2'b00);

        // Reset during ISSUE of a write drops dmem_we without waiting for a clock
        do_reset();
        @(posedge clk);
        #1 drive(1, 32'h60, 2'b11, 2'b00, 32'hCAFE, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("ri_issue_we", dmem_we, 2'b11);
        #1 reset = 1'b1;
        #1;
        check("ri_async_we", {dmem_we, dmem_r}, 4'h0);
        check("ri_async_addr", dmem_daddr, 32'h0);

        // Randomized traffic against a cycle-scheduled transaction model
        do_reset();
        emu_mem.delete();
        for (int i = 0; i < NCYC + 4; i++) begin
            x_we[i] = 0; x_r[i] = 0; x_rv[i] = 0; x_addr[i] = 0; x_wd[i] = 0; x_rd[i] = 0;
        end
        pend[0] = 0; pend[1] = 0;
        free_c = 0;
        rptr = 0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            for (int n = 0; n < 2; n++) begin
                if (!pend[n]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        int k;
                        k = int'($urandom_range(0, 5));
                        pend[n] = 1;
                        pa[n] = 32'($urandom_range(0, 7)) << 2;
                        pw[n] = $urandom;
                        pwe[n] = (k <= 1 || k == 4) ? 2'($urandom_range(1, 3)) : 2'b00;
                        pr[n] = (k == 2 || k == 3 || k == 4) ? 2'($urandom_range(1, 3)) : 2'b00;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[n] = 0;
                end
            end
            drive(pend[0], pa[0], pwe[0], pr[0], pw[0], pend[1], pa[1], pwe[1], pr[1], pw[1]);

            exp_rdy = 2'b00;
            if (c >= free_c && (pend[0] || pend[1])) begin
                w = (pend[0] && pend[1]) ? int'(rptr) : (pend[1] ? 1 : 0);
                exp_rdy[w] = 1'b1;
                rptr = (w == 0);
                op_we = pwe[w];
                op_r = (op_we != 2'b00) ? 2'b00 : pr[w];
                x_we[c+1] = op_we;
                x_r[c+1] = op_r;
                x_addr[c+1] = pa[w];
                x_wd[c+1] = pw[w];
                if (op_we != 2'b00) ref_mem[pa[w]] = pw[w];
                if (op_r != 2'b00) begin
                    x_rv[c+2][w] = 1'b1;
                    x_rd[c+2] = ref_mem.exists(pa[w]) ? ref_mem[pa[w]] : 32'h0;
                    free_c = c + 3;
                end else begin
                    free_c = c + 2;
                end
            end

            @(negedge clk);
            check("rnd_ready", {req1_ready, req0_ready}, exp_rdy);
            check("rnd_we_r", {dmem_we, dmem_r}, {x_we[c], x_r[c]});
            if ((x_we[c] | x_r[c]) != 2'b00) check("rnd_daddr", dmem_daddr, x_addr[c]);
            if (x_we[c] != 2'b00) check("rnd_indata", dmem_indata, x_wd[c]);
            check("rnd_rvalid", {req1_rvalid, req0_rvalid}, x_rv[c]);
            exp_rd = {x_rv[c][1] ? x_rd[c] : 32'h0, x_rv[c][0] ? x_rd[c] : 32'h0};
            check("rnd_rdata", {req1_rdata, req0_rdata}, exp_rd);
            for (int n = 0; n < 2; n++)
                if (exp_rdy[n]) pend[n] = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 32, as the address width of requesters and dmem.
REQ-002 The block SHALL take parameter DATA_W, default 32, as the write/read data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 For each requester N in {0,1}, the block SHALL have these ports:
  - reqN_valid, input, 1: request pending.
  - reqN_addr, input, ADDR_W: byte address.
  - reqN_we, input, 2: write size code.
  - reqN_r, input, 2: read size code.
  - reqN_wdata, input, DATA_W: store data.
REQ-006 For each requester N, the block SHALL have these ports:
  - reqN_ready, output, 1: request accepted this cycle.
  - reqN_rvalid, output, 1: read data valid.
  - reqN_rdata, output, DATA_W: read data.
REQ-007 The block SHALL drive these dmem ports:
  - dmem_daddr, output, ADDR_W.
  - dmem_we, output, 2.
  - dmem_indata, output, DATA_W.
  - dmem_r, output, 2.
  - dmem_outdata, input, DATA_W.

Function
REQ-008 The block SHALL implement FSM states IDLE, ISSUE and WAIT.
REQ-009 In IDLE with at least one reqN_valid high, the block SHALL:
  - select a winner;
  - assert that winner's reqN_ready combinationally for exactly that cycle;
  - capture the winner's addr/we/r/wdata and its index;
  - go to ISSUE.
REQ-010 In IDLE with no valid request, the block SHALL stay in IDLE with both ready signals low.
REQ-011 Arbitration SHALL be round-robin:
  - a single valid request always wins;
  - when both are valid, the requester selected by a 1-bit priority pointer wins;
  - the pointer flips to the non-winner after every grant.
REQ-012 In ISSUE, the block SHALL drive dmem_daddr, dmem_indata, dmem_we and dmem_r from the captured registers; in every other state dmem_we and dmem_r SHALL be 2'b00.
REQ-013 ISSUE SHALL last exactly one cycle:
  - next state WAIT if captured r≠0 and we=0;
  - otherwise next state IDLE.
REQ-014 If captured we≠0 and r≠0, the request SHALL be treated as a write: dmem_r forced to 0 in ISSUE and no rvalid.
REQ-015 If captured we=0 and r=0, the request SHALL be accepted as a no-op: dmem idle, no rvalid.
REQ-016 dmem SHALL sample its inputs on the rising edge ending ISSUE and present dmem_outdata during WAIT.
REQ-017 In WAIT, the block SHALL:
  - assert reqN_rvalid of the captured index for exactly one cycle;
  - drive reqN_rdata = dmem_outdata combinationally;
  - go to IDLE.
REQ-018 The non-granted requester's rvalid SHALL be 0 at all times; its rdata SHALL be 0 whenever its rvalid is low.
REQ-019 Latency and throughput SHALL be:
  - write: ready in cycle T, dmem_we in T+1;
  - read: rvalid in T+2;
  - next grant no earlier than T+2 for writes and T+3 for reads.
REQ-020 Requesters SHALL hold valid and payload stable until ready. The block SHALL ignore payload changes after capture, and a requester deasserting valid before ready SHALL lose no state.

Reset
REQ-021 While reset is high, the block SHALL set:
  - state IDLE and priority pointer 0;
  - captured registers 0;
  - all reqN_ready, reqN_rvalid, reqN_rdata, dmem_we, dmem_r, dmem_daddr and dmem_indata 0.
REQ-022 Reset asserted in ISSUE or WAIT SHALL abort the transaction: no rvalid is produced and dmem_we drops to 0 asynchronously.

Structure
REQ-023 State encodings and the dmem size-code constants (2'b00 none, 2'b01 byte, 2'b10 half, 2'b11 word) SHALL live in the shared package dmem_pkg.
REQ-024 The round-robin selector SHALL be the single sub-module rr_arb2: inputs valid[1:0] and pointer; outputs grant[1:0], one-hot or zero.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
  - Single write: req0 addr=0x10, we=2'b11, wdata=0xDEADBEEF → req0_ready at T; dmem_we=2'b11, daddr=0x10, indata=0xDEADBEEF at T+1; IDLE at T+2.
  - Single read: after the write, req1 addr=0x10, r=2'b11 → req1_ready at T; dmem_r=2'b11 at T+1; req1_rvalid with rdata=0xDEADBEEF at T+2; req0_rvalid stays 0.
  - Contention: both valid, continuous reads, after reset → grant order 0,1,0,1; each grant 3 cycles apart.
  - Conflict: we=2'b10 and r=2'b11 together → dmem_we=2'b10, dmem_r=0, no rvalid.
  - Reset in WAIT: read issued, reset pulsed during WAIT → no rvalid; state IDLE; pointer 0; dmem_we/r 0 immediately.
  - Payload change: addr changed from 0x20 to 0x40 in the cycle after ready → dmem_daddr=0x20.
